// File: rtl/store_checker.sv
// store_checker
//
// Self-check monitor for the core's data-memory write port. It holds a
// programmable table of expected (address, data) stores and compares every
// memory write against that table. It counts matches, recognises the
// completion signature and captures the first unexpected store. It runs the
// same way in simulation and on FPGA next to the core.
//
// Ports
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   cfg_we/idx/addr/   table entry write, accepted in IDLE only
//   cfg_data/cfg_cnt
//   cfg_ordered        match mode latched at start (1 = in-order)
//   cfg_num            number of valid entries latched at start
//   start              IDLE/DONE/FAIL -> RUN; table kept, run state cleared
//   MemWrite, DataAdr, store strobe, address and data from the core
//   WriteData
//   pass_count         counted matches, saturating at DEPTH
//   done, fail         sticky completion / failure flags
//   fail_addr/data     first failing store
//   busy               high while in RUN
//
// state | meaning
// IDLE  | table programmable, waiting for start
// RUN   | every store is checked against the table
// DONE  | completion signature seen with no prior failure (terminal)
// FAIL  | unexpected store captured (terminal)

module store_checker #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int DONE_ADDR = 40,
    parameter int DONE_DATA = 30,
    parameter int IGN_LO    = 96,
    parameter int IGN_HI    = 99
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [DATA_W-1:0]        cfg_data,
    input  logic                     cfg_cnt,
    input  logic                     cfg_ordered,
    input  logic [$clog2(DEPTH):0]   cfg_num,
    input  logic                     start,
    input  logic                     MemWrite,
    input  logic [ADDR_W-1:0]        DataAdr,
    input  logic [DATA_W-1:0]        WriteData,
    output logic [$clog2(DEPTH):0]   pass_count,
    output logic                     done,
    output logic                     fail,
    output logic [ADDR_W-1:0]        fail_addr,
    output logic [DATA_W-1:0]        fail_data,
    output logic                     busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [ADDR_W-1:0] DONE_A    = ADDR_W'(DONE_ADDR);
    localparam logic [DATA_W-1:0] DONE_D    = DATA_W'(DONE_DATA);
    localparam logic [ADDR_W-1:0] IGN_LO_A  = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_HI_A  = ADDR_W'(IGN_HI);
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t state, stateNext;

    // Expected-store table; contents are undefined after reset.
    logic [ADDR_W-1:0] tblAddr [DEPTH];
    logic [DATA_W-1:0] tblData [DEPTH];
    logic [DEPTH-1:0]  tblCnt;

    logic              orderedLat;
    logic [CNT_W-1:0]  numLat;
    logic [CNT_W-1:0]  ptr;
    logic [DEPTH-1:0]  hitMap;
    logic [CNT_W-1:0]  passCnt;
    logic [ADDR_W-1:0] failAddr;
    logic [DATA_W-1:0] failData;

    logic              isDoneSig;
    logic              inIgnore;
    logic [IDX_W-1:0]  ptrIdx;
    logic              ioMatch;
    logic              uoMatch;
    logic [IDX_W-1:0]  uoIdx;
    logic              dupMatch;

    logic              rearm;
    logic              advancePtr;
    logic              setHit;
    logic              countInc;
    logic              captureFail;

    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we) begin
            tblAddr[cfg_idx] <= cfg_addr;
            tblData[cfg_idx] <= cfg_data;
            tblCnt[cfg_idx]  <= cfg_cnt;
        end
    end

    // Store classification against the table.
    always_comb begin
        isDoneSig = (DataAdr == DONE_A) && (WriteData == DONE_D);
        inIgnore  = (DataAdr >= IGN_LO_A) && (DataAdr <= IGN_HI_A);

        // numLat never exceeds DEPTH, so ptr < numLat keeps ptrIdx in range.
        ptrIdx  = ptr[IDX_W-1:0];
        ioMatch = (ptr < numLat) && (tblAddr[ptrIdx] == DataAdr) &&
                  (tblData[ptrIdx] == WriteData);

        // Scan from the top down so the lowest matching index is the one kept.
        uoMatch  = 1'b0;
        uoIdx    = '0;
        dupMatch = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < numLat) && (tblAddr[i] == DataAdr) &&
                (tblData[i] == WriteData)) begin
                if (!hitMap[i]) begin
                    uoMatch = 1'b1;
                    uoIdx   = IDX_W'(i);
                end else begin
                    dupMatch = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        rearm       = 1'b0;
        advancePtr  = 1'b0;
        setHit      = 1'b0;
        countInc    = 1'b0;
        captureFail = 1'b0;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    stateNext = RUN;
                    rearm     = 1'b1;
                end
            end
            RUN: begin
                if (MemWrite) begin
                    if (isDoneSig) begin
                        stateNext = DONE;
                    end else if (orderedLat && ioMatch) begin
                        advancePtr = 1'b1;
                        countInc   = tblCnt[ptrIdx];
                    end else if (!orderedLat && uoMatch) begin
                        setHit   = 1'b1;
                        countInc = tblCnt[uoIdx];
                    end else if ((!orderedLat && dupMatch) || inIgnore) begin
                        // accepted without counting
                    end else begin
                        captureFail = 1'b1;
                        stateNext   = FAIL;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            orderedLat <= 1'b0;
            numLat     <= '0;
            ptr        <= '0;
            hitMap     <= '0;
            passCnt    <= '0;
            failAddr   <= '0;
            failData   <= '0;
        end else if (rearm) begin
            orderedLat <= cfg_ordered;
            numLat     <= (cfg_num > CNT_DEPTH) ? CNT_DEPTH : cfg_num;
            ptr        <= '0;
            hitMap     <= '0;
            passCnt    <= '0;
            failAddr   <= '0;
            failData   <= '0;
        end else begin
            if (advancePtr) begin
                ptr <= ptr + CNT_W'(1);
            end
            if (setHit) begin
                hitMap[uoIdx] <= 1'b1;
            end
            if (countInc && (passCnt != CNT_DEPTH)) begin
                passCnt <= passCnt + CNT_W'(1);
            end
            if (captureFail) begin
                failAddr <= DataAdr;
                failData <= WriteData;
            end
        end
    end

    assign pass_count = passCnt;
    assign done       = (state == DONE);
    assign fail       = (state == FAIL);
    assign busy       = (state == RUN);
    assign fail_addr  = failAddr;
    assign fail_data  = failData;

endmodule

// File: tb/tb_store_checker.sv
module tb_store_checker;

    localparam int OP_RST   = 0;
    localparam int OP_CFG   = 1;
    localparam int OP_START = 2;
    localparam int OP_ST    = 3;
    localparam int OP_NOP   = 4;

    typedef struct {
        int          op;
        int          idx;
        logic [31:0] a;
        logic [31:0] d;
        bit          b;
        int          num;
        int          ePass;
        bit          eDone;
        bit          eFail;
        bit          eBusy;
        bit          chkCap;
        logic [31:0] eFa;
        logic [31:0] eFd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_cnt = 1'b0;
    logic        cfg_ordered = 1'b0;
    logic [2:0]  cfg_num = '0;
    logic        start = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [2:0]  pass_count;
    logic        done;
    logic        fail;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;
    logic        busy;

    int   nChecks = 0;
    int   nFails  = 0;
    vec_t vecs[128];
    int   nVec = 0;

    store_checker #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_cnt(cfg_cnt), .cfg_ordered(cfg_ordered),
        .cfg_num(cfg_num), .start(start),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .pass_count(pass_count), .done(done), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic checkAll(string tag, int ep, bit ed, bit ef, bit eb,
                            bit cc, logic [31:0] fa, logic [31:0] fd);
        chk({tag, " pass_count"}, 32'(pass_count), ep);
        chk({tag, " done"}, 32'(done), 32'(ed));
        chk({tag, " fail"}, 32'(fail), 32'(ef));
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        if (cc) begin
            chk({tag, " fail_addr"}, fail_addr, fa);
            chk({tag, " fail_data"}, fail_data, fd);
        end
    endtask

    task automatic add(int op, int idx, int a, int d, bit b, int num,
                       int ep, bit ed, bit ef, bit eb, bit cc, int fa, int fd);
        vecs[nVec].op     = op;
        vecs[nVec].idx    = idx;
        vecs[nVec].a      = a;
        vecs[nVec].d      = d;
        vecs[nVec].b      = b;
        vecs[nVec].num    = num;
        vecs[nVec].ePass  = ep;
        vecs[nVec].eDone  = ed;
        vecs[nVec].eFail  = ef;
        vecs[nVec].eBusy  = eb;
        vecs[nVec].chkCap = cc;
        vecs[nVec].eFa    = fa;
        vecs[nVec].eFd    = fd;
        nVec++;
    endtask

    // Shorthands: reset/config leave everything at zero; start gives busy.
    task automatic rstV();
        add(OP_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endtask
    task automatic cfgV(int idx, int a, int d, bit cnt);
        add(OP_CFG, idx, a, d, cnt, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic startV(bit ord, int num);
        add(OP_START, 0, 0, 0, ord, num, 0, 0, 0, 1, 1, 0, 0);
    endtask
    task automatic stV(int a, int d, int ep, bit ed, bit ef, bit eb);
        add(OP_ST, 0, a, d, 0, 0, ep, ed, ef, eb, 0, 0, 0);
    endtask
    task automatic stFail(int a, int d, int ep, int fa, int fd);
        add(OP_ST, 0, a, d, 0, 0, ep, 0, 1, 0, 1, fa, fd);
    endtask

    task automatic doStore(int a, int d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic doStart(bit ord, int num);
        start       = 1'b1;
        cfg_ordered = ord;
        cfg_num     = 3'(num);
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    initial begin
        // Unordered, three counted entries, stores out of order then done.
        rstV();
        cfgV(0, 100, 25, 1);
        cfgV(1, 104, 4096, 1);
        cfgV(2, 108, 4184, 1);
        startV(0, 3);
        stV(108, 4184, 1, 0, 0, 1);
        stV(100, 25, 2, 0, 0, 1);
        stV(104, 4096, 3, 0, 0, 1);
        stV(40, 30, 3, 1, 0, 0);
        // Rearm: duplicate store, ignored address, idle cycle, done.
        startV(0, 3);
        stV(100, 25, 1, 0, 0, 1);
        stV(100, 25, 1, 0, 0, 1);
        stV(97, 7, 1, 0, 0, 1);
        add(OP_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        stV(40, 30, 1, 1, 0, 0);
        // Wrong data fails; later done signature does not clear it.
        startV(0, 3);
        stFail(100, 26, 0, 100, 26);
        add(OP_ST, 0, 40, 30, 0, 0, 0, 0, 1, 0, 1, 100, 26);
        // cfg_num = 0: table entries are not valid.
        startV(0, 0);
        stFail(100, 25, 0, 100, 25);
        // Ignore window edges.
        startV(0, 0);
        stV(99, 1, 0, 0, 0, 1);
        stV(96, 1, 0, 0, 0, 1);
        stFail(95, 1, 0, 95, 1);
        // Reset clears the capture registers.
        rstV();
        // In-order table.
        cfgV(0, 160, -35, 1);
        cfgV(1, 164, -64, 0);
        startV(1, 2);
        stFail(164, -64, 0, 164, -64);
        add(OP_ST, 0, 40, 30, 0, 0, 0, 0, 1, 0, 1, 164, -64);
        startV(1, 2);
        stV(160, -35, 1, 0, 0, 1);
        stV(164, -64, 1, 0, 0, 1);
        stFail(200, 5, 1, 200, 5);
        // Pointer exhausted: a repeat of entry 0 is no longer accepted.
        startV(1, 2);
        stV(160, -35, 1, 0, 0, 1);
        stV(164, -64, 1, 0, 0, 1);
        stFail(160, -35, 1, 160, -35);
        // Ignored address in-order, then done.
        startV(1, 2);
        stV(98, 3, 0, 0, 0, 1);
        stV(40, 30, 0, 1, 0, 0);
        // Full table at DEPTH = 4.
        rstV();
        cfgV(0, 200, 1, 1);
        cfgV(1, 204, 2, 1);
        cfgV(2, 208, 3, 1);
        cfgV(3, 212, 4, 1);
        startV(0, 4);
        stV(212, 4, 1, 0, 0, 1);
        stV(200, 1, 2, 0, 0, 1);
        stV(208, 3, 3, 0, 0, 1);
        stV(204, 2, 4, 0, 0, 1);
        stV(200, 1, 4, 0, 0, 1);
        stV(40, 30, 4, 1, 0, 0);
        // Rearm; a table write during RUN must be ignored.
        startV(0, 4);
        add(OP_CFG, 0, 300, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        stV(200, 1, 1, 0, 0, 1);
        stV(204, 2, 2, 0, 0, 1);
        stV(208, 3, 3, 0, 0, 1);
        stV(212, 4, 4, 0, 0, 1);
        stV(212, 4, 4, 0, 0, 1);
        stV(40, 30, 4, 1, 0, 0);

        for (int i = 0; i < nVec; i++) begin
            vec_t v;
            v = vecs[i];
            case (v.op)
                OP_RST: begin
                    reset = 1'b0;
                    @(posedge clk);
                    #1;
                    reset = 1'b1;
                end
                OP_CFG: begin
                    cfg_we   = 1'b1;
                    cfg_idx  = 2'(v.idx);
                    cfg_addr = v.a;
                    cfg_data = v.d;
                    cfg_cnt  = v.b;
                    @(posedge clk);
                    #1;
                    cfg_we   = 1'b0;
                end
                OP_START: doStart(v.b, v.num);
                OP_ST:    doStore(v.a, v.d);
                default: begin
                    @(posedge clk);
                    #1;
                end
            endcase
            checkAll($sformatf("vec%0d", i), v.ePass, v.eDone, v.eFail,
                     v.eBusy, v.chkCap, v.eFa, v.eFd);
        end

        // Reset mid-RUN after two counted matches: outputs clear at once.
        doStart(0, 4);
        doStore(200, 1);
        doStore(204, 2);
        checkAll("midrun before reset", 2, 0, 0, 1, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checkAll("midrun async reset", 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // start together with a store in IDLE: the store is not evaluated.
        start       = 1'b1;
        cfg_ordered = 1'b0;
        cfg_num     = 3'd4;
        MemWrite    = 1'b1;
        DataAdr     = 32'd200;
        WriteData   = 32'd1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        MemWrite = 1'b0;
        checkAll("start with store", 0, 0, 0, 1, 0, 0, 0);
        // Table survives the reset; counting restarts from zero.
        doStore(208, 3);
        checkAll("after reset store1", 1, 0, 0, 1, 0, 0, 0);
        doStore(200, 1);
        checkAll("after reset store2", 2, 0, 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
